// File: rtl/screen_fade_pkg.sv
// Shared widths, brightness limits and fade state encoding for the screen_fade
// output stage and its per-channel scaler.
package screen_fade_pkg;

    localparam int COUNT_W  = 12;
    localparam int RGB_W    = 12;
    localparam int CHAN_W   = 4;
    localparam int BRIGHT_W = 5;
    localparam int CNT_W    = 8;
    localparam int PROD_W   = 8;

    localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        HOLD_BLACK,
        FADE_IN
    } fade_state_e;

    // 4-bit colour times 5-bit brightness; the largest product is 15*16 = 240.
    function automatic logic [PROD_W-1:0] scale_product(
        input logic [CHAN_W-1:0]   chan,
        input logic [BRIGHT_W-1:0] bright
    );
        return PROD_W'(chan) * PROD_W'(bright);
    endfunction

endpackage

// File: rtl/screen_fade_if.sv
// VGA timing + colour bundle passed between pipeline stages; the producer
// uses the master modport and the consumer uses the slave modport.
interface screen_fade_if;

    logic [screen_fade_pkg::COUNT_W-1:0] hcount;
    logic [screen_fade_pkg::COUNT_W-1:0] vcount;
    logic                                hsync;
    logic                                vsync;
    logic                                hblnk;
    logic                                vblnk;
    logic [screen_fade_pkg::RGB_W-1:0]   rgb;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

endinterface

// File: rtl/fade_scale.sv
// One colour channel of the fade: stage 1 registers channel*brightness, stage 2
// shifts it down by 4 and blanks it. Define SCREEN_FADE_DITHER_EN for 2x2 ordered rounding.
module fade_scale
    import screen_fade_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [CHAN_W-1:0]   chan,
    input  logic [BRIGHT_W-1:0] bright,
    input  logic                dither,
    input  logic                blank,
    output logic [CHAN_W-1:0]   chan_scaled
);

    logic [PROD_W-1:0] product;
    logic [PROD_W-1:0] rounded;

    always_ff @(posedge clk) begin
        if (!reset) begin
            product <= '0;
        end else begin
            product <= scale_product(chan, bright);
        end
    end

`ifdef SCREEN_FADE_DITHER_EN
    // Half-LSB offset on a checkerboard; 240 + 8 still fits, so no clamp is needed.
    assign rounded = product + (dither ? PROD_W'(8) : PROD_W'(0));
`else
    logic unused_dither;
    assign unused_dither = dither;
    assign rounded       = product;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            chan_scaled <= '0;
        end else if (blank) begin
            chan_scaled <= '0;
        end else begin
            chan_scaled <= rounded[PROD_W-1:PROD_W-CHAN_W];
        end
    end

endmodule

// File: rtl/screen_fade.sv
// Final VGA stage: 2-cycle timing pass-through with frame-synchronous fade to
// black and back. Optional ordered dither via SCREEN_FADE_DITHER_EN.
module screen_fade
    import screen_fade_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 8,
    parameter int START_BLACK     = 0
) (
    input  logic          clk,
    input  logic          reset,
    screen_fade_if.slave  vga_in,
    screen_fade_if.master vga_out,
    input  logic          fade_trigger,
    output logic          fade_busy,
    output logic          fade_mid
);

    localparam logic [CNT_W-1:0]    STEP_LAST    = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [CNT_W-1:0]    HOLD_LAST    = (HOLD_FRAMES == 0) ? '0 : CNT_W'(HOLD_FRAMES - 1);
    localparam fade_state_e         RESET_STATE  = (START_BLACK != 0) ? FADE_IN : IDLE;
    localparam logic [BRIGHT_W-1:0] RESET_BRIGHT = (START_BLACK != 0) ? '0 : BRIGHT_MAX;

    fade_state_e         state, state_next;
    logic [BRIGHT_W-1:0] bright, bright_next;
    logic [CNT_W-1:0]    frame_cnt, frame_cnt_next;
    logic                busy_next, mid_next;
    logic                vsync_prev;
    logic                frame_tick;

    logic [COUNT_W-1:0]  hcount_d1, vcount_d1;
    logic                hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
    logic [CHAN_W-1:0]   red_scaled, green_scaled, blue_scaled;

    assign frame_tick = vga_in.vsync & ~vsync_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RESET_STATE;
            bright     <= RESET_BRIGHT;
            frame_cnt  <= '0;
            vsync_prev <= 1'b0;
            fade_busy  <= 1'b0;
            fade_mid   <= 1'b0;
        end else begin
            state      <= state_next;
            bright     <= bright_next;
            frame_cnt  <= frame_cnt_next;
            vsync_prev <= vga_in.vsync;
            fade_busy  <= busy_next;
            fade_mid   <= mid_next;
        end
    end

    // A trigger in IDLE wins over a coincident tick: the level stays put that frame.
    always_comb begin
        state_next     = state;
        bright_next    = bright;
        frame_cnt_next = frame_cnt;
        mid_next       = 1'b0;
        case (state)
            IDLE: begin
                bright_next = BRIGHT_MAX;
                if (fade_trigger) begin
                    state_next     = FADE_OUT;
                    frame_cnt_next = '0;
                end
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    if (frame_cnt == STEP_LAST) begin
                        bright_next    = bright - BRIGHT_W'(1);
                        frame_cnt_next = '0;
                        if (bright == BRIGHT_W'(1)) begin
                            state_next = HOLD_BLACK;
                            mid_next   = 1'b1;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt + CNT_W'(1);
                    end
                end
            end
            HOLD_BLACK: begin
                if (frame_tick) begin
                    if (frame_cnt == HOLD_LAST) begin
                        state_next     = FADE_IN;
                        frame_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt + CNT_W'(1);
                    end
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    if (frame_cnt == STEP_LAST) begin
                        bright_next    = bright + BRIGHT_W'(1);
                        frame_cnt_next = '0;
                        if (bright == BRIGHT_MAX - BRIGHT_W'(1)) begin
                            state_next = IDLE;
                        end
                    end else begin
                        frame_cnt_next = frame_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hcount_d1 <= '0;
            vcount_d1 <= '0;
            hsync_d1  <= 1'b0;
            vsync_d1  <= 1'b0;
            hblnk_d1  <= 1'b0;
            vblnk_d1  <= 1'b0;
        end else begin
            hcount_d1 <= vga_in.hcount;
            vcount_d1 <= vga_in.vcount;
            hsync_d1  <= vga_in.hsync;
            vsync_d1  <= vga_in.vsync;
            hblnk_d1  <= vga_in.hblnk;
            vblnk_d1  <= vga_in.vblnk;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
        end else begin
            vga_out.hcount <= hcount_d1;
            vga_out.vcount <= vcount_d1;
            vga_out.hsync  <= hsync_d1;
            vga_out.vsync  <= vsync_d1;
            vga_out.hblnk  <= hblnk_d1;
            vga_out.vblnk  <= vblnk_d1;
        end
    end

    // Dither and blanking both come from stage 1 so they align with the stored products.
    fade_scale u_scale_red (
        .clk         (clk),
        .reset       (reset),
        .chan        (vga_in.rgb[11:8]),
        .bright      (bright),
        .dither      (hcount_d1[0] ^ vcount_d1[0]),
        .blank       (hblnk_d1 | vblnk_d1),
        .chan_scaled (red_scaled)
    );

    fade_scale u_scale_green (
        .clk         (clk),
        .reset       (reset),
        .chan        (vga_in.rgb[7:4]),
        .bright      (bright),
        .dither      (hcount_d1[0] ^ vcount_d1[0]),
        .blank       (hblnk_d1 | vblnk_d1),
        .chan_scaled (green_scaled)
    );

    fade_scale u_scale_blue (
        .clk         (clk),
        .reset       (reset),
        .chan        (vga_in.rgb[3:0]),
        .bright      (bright),
        .dither      (hcount_d1[0] ^ vcount_d1[0]),
        .blank       (hblnk_d1 | vblnk_d1),
        .chan_scaled (blue_scaled)
    );

    assign vga_out.rgb = {red_scaled, green_scaled, blue_scaled};

endmodule
